// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped read-only instruction cache with block refill
module icache_direct_mapped #(
    parameter int LINES  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    output logic [31:0]       readinst,
    output logic              busywait,
    output logic              mem_read,
    output logic [ADDR_W-5:0] mem_address,
    input  logic [127:0]      mem_readdata,
    input  logic              mem_busywait
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 4 - IDX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t             state;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags [LINES];
    logic [127:0]       data [LINES];

    logic [IDX_W-1:0]   index;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         offset;
    logic [127:0]       line;
    logic               hit;
    logic               unused_byte_bits;

    assign index            = address[4 +: IDX_W];
    assign tag              = address[ADDR_W-1 -: TAG_W];
    assign offset           = address[3:2];
    assign unused_byte_bits = ^address[1:0];

    assign line        = data[index];
    assign hit         = valid[index] && (tags[index] == tag);
    assign readinst    = valid[index] ? line[{offset, 5'd0} +: 32] : 32'd0;
    // A miss stalls the CPU in the very cycle it is seen; the whole refill keeps it stalled.
    assign busywait    = (state != IDLE) || (read && !hit);
    assign mem_address = address[ADDR_W-1:4];

    // Refill sequencer; mem_read is a registered copy of "in MEM_READ", valid bits live here so reset clears them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            mem_read <= 1'b0;
            valid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read && !hit) begin
                        state    <= MEM_READ;
                        mem_read <= 1'b1;
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        state    <= UPDATE;
                        mem_read <= 1'b0;
                    end
                end
                UPDATE: begin
                    valid[index] <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    mem_read <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays are written only on install; a reset in that cycle drops the block.
    always_ff @(posedge clock) begin
        if (reset && state == UPDATE) begin
            tags[index] <= tag;
            data[index] <= mem_readdata;
        end
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - randomized bench with behavioural cache and memory model
module tb_icache_direct_mapped;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         read = 1'b0;
    logic [9:0]   address = '0;
    logic [31:0]  readinst;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int total = 0;
    int bad   = 0;

    icache_direct_mapped #(.LINES(8), .ADDR_W(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .readinst     (readinst),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    // Instruction memory: static byte array, random latency per request, block held after delivery
    logic [7:0]   mem_bytes [1024];
    logic [127:0] cur_blk;
    logic [127:0] held_blk;
    int           mcnt = 0;
    int           mlat = 2;

    always_comb begin
        cur_blk = '0;
        for (int k = 0; k < 16; k++)
            cur_blk[8*k +: 8] = mem_bytes[{mem_address, 4'(k)}];
    end

    assign mem_busywait = mem_read && (mcnt < mlat);
    assign mem_readdata = (mem_read && !mem_busywait) ? cur_blk : held_blk;

    always @(posedge clock) begin
        if (!mem_read) begin
            mcnt <= 0;
            mlat <= $urandom_range(1, 4);
        end else if (mem_busywait) begin
            mcnt <= mcnt + 1;
        end else begin
            held_blk <= cur_blk;
        end
    end

    // Behavioural cache: which memory block each line holds, plus refill progress
    logic       m_valid [8];
    logic [2:0] m_tag   [8];
    int         m_phase = 0;   // 0 idle, 1 waiting on memory, 2 installing
    logic       last_bw = 1'b0;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {mem_bytes[b + 10'd3], mem_bytes[b + 10'd2], mem_bytes[b + 10'd1], mem_bytes[b]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive after the edge, compare mid-cycle, then advance the model across the next edge
    task automatic step(input logic r, input logic [9:0] a, input logic rst);
        logic [2:0]  idx;
        logic [2:0]  tg;
        logic        m_hit;
        logic        exp_bw;
        logic        exp_mr;
        logic [31:0] exp_ri;
        @(posedge clock);
        #1;
        read    = r;
        address = a;
        reset   = rst;
        @(negedge clock);
        idx    = a[6:4];
        tg     = a[9:7];
        m_hit  = m_valid[idx] && (m_tag[idx] == tg);
        exp_ri = m_valid[idx] ? mem_word({m_tag[idx], idx, a[3:0]}) : 32'd0;
        exp_bw = (m_phase != 0) || (r && !m_hit);
        exp_mr = (m_phase == 1);
        chk("readinst", readinst, exp_ri);
        chk("busywait", busywait, exp_bw);
        chk("mem_read", mem_read, exp_mr);
        if (exp_mr) chk("mem_address", mem_address, a[9:4]);
        last_bw = exp_bw;
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (r && !m_hit) m_phase = 1;
        end else if (m_phase == 1) begin
            if (!mem_busywait) m_phase = 2;
        end else begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_phase      = 0;
        end
    endtask

    task automatic run_to_hit(input string nm, input logic [9:0] a, input logic [31:0] exp_word,
                              input logic exp_miss, input logic [5:0] exp_blk);
        int         n;
        logic [5:0] seen;
        logic       any_mr;
        n      = 0;
        seen   = '1;
        any_mr = 1'b0;
        step(1'b1, a, 1'b1);
        chk({nm, " first busywait"}, busywait, exp_miss);
        while (busywait && n < 20) begin
            step(1'b1, a, 1'b1);
            if (mem_read) begin
                any_mr = 1'b1;
                seen   = mem_address;
            end
            n++;
        end
        if (n >= 20) chk({nm, " timeout"}, 1, 0);
        chk({nm, " word"}, readinst, exp_word);
        chk({nm, " stall released"}, busywait, 1'b0);
        chk({nm, " refill issued"}, any_mr, exp_miss);
        if (exp_miss) chk({nm, " block"}, seen, exp_blk);
    endtask

    initial begin
        logic       cur_r;
        logic [9:0] cur_a;
        logic       rst;
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       cur_r;
        logic [9:0] cur_a;
        logic       rst;
        for (int i = 0; i < 1024; i++) mem_bytes[i] = 8'($urandom);
        {mem_bytes[3],   mem_bytes[2],   mem_bytes[1],   mem_bytes[0]}   = 32'h00000008;
        {mem_bytes[7],   mem_bytes[6],   mem_bytes[5],   mem_bytes[4]}   = 32'h00010005;
        {mem_bytes[11],  mem_bytes[10],  mem_bytes[9],   mem_bytes[8]}   = 32'h02020001;
        {mem_bytes[19],  mem_bytes[18],  mem_bytes[17],  mem_bytes[16]}  = 32'h01040003;
        {mem_bytes[131], mem_bytes[130], mem_bytes[129], mem_bytes[128]} = 32'h08050000;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;

        repeat (2) @(posedge clock);
        step(1'b0, 10'h000, 1'b0);
        step(1'b1, 10'h000, 1'b0);
        chk("reset busywait follows read", busywait, 1'b1);
        chk("reset readinst", readinst, 32'd0);

        run_to_hit("cold 0x000", 10'h000, 32'h00000008, 1'b1, 6'd0);
        run_to_hit("hit 0x004", 10'h004, 32'h00010005, 1'b0, 6'd0);
        run_to_hit("hit 0x008", 10'h008, 32'h02020001, 1'b0, 6'd0);
        run_to_hit("miss 0x010", 10'h010, 32'h01040003, 1'b1, 6'd1);
        run_to_hit("rehit 0x000", 10'h000, 32'h00000008, 1'b0, 6'd0);
        run_to_hit("conflict 0x080", 10'h080, 32'h08050000, 1'b1, 6'd8);
        run_to_hit("evicted 0x000", 10'h000, 32'h00000008, 1'b1, 6'd0);

        step(1'b1, 10'h100, 1'b1);
        step(1'b1, 10'h100, 1'b1);
        chk("midfill mem_read before reset", mem_read, 1'b1);
        step(1'b1, 10'h100, 1'b0);
        step(1'b1, 10'h000, 1'b1);
        chk("midfill mem_read after reset", mem_read, 1'b0);
        chk("midfill valid cleared", busywait, 1'b1);
        run_to_hit("after reset 0x000", 10'h000, 32'h00000008, 1'b1, 6'd0);

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 10'($urandom), 1'b1);
            chk("idle busywait", busywait, 1'b0);
            chk("idle mem_read", mem_read, 1'b0);
        end

        cur_r = 1'b0;
        cur_a = '0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            if (m_phase != 0 || last_bw) begin
                cur_r = 1'b1;
            end else begin
                cur_r = ($urandom_range(0, 5) != 0);
                cur_a = 10'($urandom_range(0, 1023));
                if ($urandom_range(0, 1) == 1) cur_a[9:7] = 3'($urandom_range(0, 1));
            end
            step(cur_r, cur_a, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped instruction cache between the CPU fetch stage (PC side) and the 16-byte-block instruction memory (64 blocks, 6-bit block address, 128-bit block read with read/busywait handshake).
- Serves 32-bit instruction words on a hit with zero extra cycles.
- On a miss, stalls the CPU, fetches the whole 16-byte block from instruction memory, installs it, then serves the word.

Parameters:
- LINES, 8, number of cache lines (index width = log2(LINES) = 3).
- ADDR_W, 10, CPU byte-address width (1024-byte instruction space).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-low: sampled on posedge clock; 0 = reset.
- read  in  1  CPU fetch request; held high while a fetch is outstanding.
- address  in  10  CPU byte address (PC). Held stable by the CPU while busywait=1.
- readinst  out  32  instruction word for address; valid when read=1 and busywait=0.
- busywait  out  1  CPU stall.
- mem_read  out  1  block read request to instruction memory.
- mem_address  out  6  block address to instruction memory = address[9:4].
- mem_readdata  in  128  returned block; byte k of the block is bits [8k+7:8k].
- mem_busywait  in  1  memory busy; falls when mem_readdata is valid.

Behaviour:
- Address split:
  - tag = address[9:7] (3b)
  - index = address[6:4] (3b)
  - word offset = address[3:2]
  - address[1:0] ignored
- Storage per line: valid (1b), tag (3b), data (128b). Word w = data[32w+31:32w], little-endian byte order as stored in memory.
- hit = valid[index] && tag[index] == address tag. Combinational from current address.
- readinst:
  - Combinational: selected word of line[index] when valid[index]=1.
  - 32'd0 when valid[index]=0.
- FSM states: IDLE, MEM_READ, UPDATE. Transitions on posedge clock.
  - IDLE:
    - busywait = read && !hit (combinational, same cycle as request).
    - mem_read = 0.
    - read && !hit -> MEM_READ. Otherwise stay.
    - read=0 -> busywait=0 regardless of hit.
  - MEM_READ:
    - busywait = 1, mem_read = 1, mem_address = address[9:4].
    - mem_busywait=0 at posedge -> UPDATE. Otherwise stay.
    - The first MEM_READ cycle always sees mem_busywait=1, because memory raises it combinationally on read.
  - UPDATE:
    - busywait = 1, mem_read = 0.
    - On posedge: data[index] <= mem_readdata, tag[index] <= address[9:7], valid[index] <= 1, next state IDLE.
  - Back in IDLE the request hits, so busywait falls combinationally in that cycle.
- mem_address is driven from address[9:4] in all states. It is only meaningful while mem_read=1.
- Miss latency: miss-detect cycle + N MEM_READ cycles (until mem_busywait falls) + 1 UPDATE cycle, then hit.
- Hit latency: 0 cycles (combinational).
- Replacement: direct-mapped; a fill overwrites line[index] unconditionally. No write port and no dirty state (read-only cache).
- Reset (reset=0 at posedge):
  - All valid bits cleared; state -> IDLE.
  - Tag/data contents don't-care.
  - Outputs after reset: busywait = read (every access misses), mem_read = 0, readinst = 32'd0.
- Reset mid-operation:
  - From MEM_READ or UPDATE -> IDLE with all lines invalid.
  - The in-flight block is discarded and not installed.
  - mem_read drops in the reset cycle's next state.
  - The memory's pending response is ignored.
- read deasserted during MEM_READ/UPDATE: the fill still completes (the CPU may not do this; the fill is harmless).
- Simultaneous mem_busywait fall and reset: reset wins.

Test Plan:
- Cold miss: reset low 2 cycles, then read=1, address=0x000 -> busywait=1 same cycle; next cycle mem_read=1, mem_address=6'd0; after mem_busywait falls, 1 UPDATE cycle, then readinst=0x00000008, busywait=0.
- Same-block hits: after the cold miss, address=0x004 -> readinst=0x00010005; address=0x008 -> readinst=0x02020001; busywait=0, mem_read=0 throughout.
- Second block: address=0x010 -> miss, mem_address=6'd1, then readinst=0x01040003. Address=0x000 still hits (0x00000008).
- Conflict eviction: address=0x080 (tag 1, index 0) -> miss, mem_address=6'd8, then readinst=0x08050000. Then address=0x000 -> miss again, mem_address=6'd0, refill, then 0x00000008.
- Reset mid-fill: assert reset during MEM_READ -> next cycle state IDLE, mem_read=0. After release, address=0x000 misses again (valid cleared).
- Idle: read=0 with any address -> busywait=0, mem_read=0, no state change.
